// File: rtl/sys_defs.sv
// Shared checkpoint types: tag/mask widths, per-tag checkpoint entry and the rollback FSM states.
// NUM_BR and NUM_ROB default to 4 and 32 unless defined by the build.
`ifndef NUM_BR
`define NUM_BR 4
`endif
`ifndef NUM_ROB
`define NUM_ROB 32
`endif

package sys_defs;

    localparam int NUM_BR    = `NUM_BR;
    localparam int NUM_ROB   = `NUM_ROB;
    localparam int BR_TAG_W  = (NUM_BR  > 1) ? $clog2(NUM_BR)  : 1;
    localparam int ROB_IDX_W = (NUM_ROB > 1) ? $clog2(NUM_ROB) : 1;

    typedef logic [BR_TAG_W-1:0]  BR_TAG_t;
    typedef logic [NUM_BR-1:0]    BR_MASK_t;
    typedef logic [ROB_IDX_W-1:0] ROB_IDX_t;

    typedef struct packed {
        logic     valid;
        ROB_IDX_t rob_idx;
        BR_MASK_t dep_mask;
    } CKPT_ENTRY_t;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        ROLLBACK = 2'd1,
        RECOVER  = 2'd2
    } CKPT_STATE_t;

    function automatic BR_MASK_t tag_onehot(input BR_TAG_t tag);
        return BR_MASK_t'(1) << tag;
    endfunction

endpackage

// File: rtl/br_tag_pick.sv
// Lowest-index free checkpoint tag; full is set when every tag in the mask is taken.
module br_tag_pick
    import sys_defs::*;
(
    input  BR_MASK_t valid_mask,
    output BR_TAG_t  tag,
    output logic     full
);

    // Scan high to low so the last hit, the lowest free index, wins.
    always_comb begin
        tag = '0;
        for (int i = NUM_BR - 1; i >= 0; i--) begin
            if (!valid_mask[i]) tag = BR_TAG_t'(i);
        end
    end

    assign full = &valid_mask;

endmodule

// File: rtl/branch_checkpoint_ctrl.sv
// Branch checkpoint allocator and mispredict rollback sequencer for the rename map table.
// Optional macro CKPT_BYPASS_FREE_EN: a full table may reuse the tag freed by a same-cycle correct resolve.
module branch_checkpoint_ctrl
    import sys_defs::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     en,
    input  logic     dispatch_en,
    input  logic     dispatch_is_br,
    input  ROB_IDX_t dispatch_ROB_idx,
    input  logic     br_resolve_en,
    input  BR_TAG_t  br_resolve_tag,
    input  logic     br_mispredict,
    output logic     dispatch_stall,
    output BR_TAG_t  br_tag_out,
    output BR_MASK_t br_mask_out,
    output BR_MASK_t squash_mask,
    output logic     rollback_en,
    output ROB_IDX_t ROB_rollback_idx
);

    CKPT_ENTRY_t entry_q [NUM_BR];
    CKPT_ENTRY_t entry_d [NUM_BR];
    CKPT_STATE_t state_q;
    BR_MASK_t    squash_q;
    ROB_IDX_t    rb_idx_q;

    BR_MASK_t valid_mask;
    BR_MASK_t pick_mask;
    BR_MASK_t res_clear;
    BR_MASK_t squash_next;
    BR_TAG_t  grant_tag;
    logic     no_free;
    logic     in_normal;
    logic     resolve_valid;
    logic     res_ok;
    logic     mis_ok;
    logic     alloc;

    always_comb begin
        for (int i = 0; i < NUM_BR; i++) valid_mask[i] = entry_q[i].valid;
    end

    assign in_normal     = (state_q == NORMAL);
    assign resolve_valid = entry_q[br_resolve_tag].valid;
    assign res_ok        = in_normal && br_resolve_en && !br_mispredict && resolve_valid;
    assign mis_ok        = in_normal && br_resolve_en &&  br_mispredict && resolve_valid;
    assign res_clear     = res_ok ? tag_onehot(br_resolve_tag) : '0;

`ifdef CKPT_BYPASS_FREE_EN
    // Only a full table looks through the resolving tag, so normal grants stay lowest-free.
    assign pick_mask = (&valid_mask) ? (valid_mask & ~res_clear) : valid_mask;
`else
    assign pick_mask = valid_mask;
`endif

    br_tag_pick u_pick (
        .valid_mask (pick_mask),
        .tag        (grant_tag),
        .full       (no_free)
    );

    assign dispatch_stall = (dispatch_is_br && no_free)
                          || (br_resolve_en && br_mispredict)
                          || !in_normal;
    assign alloc = dispatch_en && dispatch_is_br && !dispatch_stall;

    // The mispredicting branch plus every live checkpoint allocated while it was live.
    always_comb begin
        squash_next = tag_onehot(br_resolve_tag);
        for (int i = 0; i < NUM_BR; i++) begin
            if (entry_q[i].valid && entry_q[i].dep_mask[br_resolve_tag]) squash_next[i] = 1'b1;
        end
    end

    always_comb begin
        entry_d = entry_q;
        for (int i = 0; i < NUM_BR; i++) begin
            if (mis_ok) begin
                if (squash_next[i]) entry_d[i].valid = 1'b0;
                entry_d[i].dep_mask = entry_q[i].dep_mask & ~squash_next;
            end else begin
                entry_d[i].dep_mask = entry_q[i].dep_mask & ~res_clear;
                if (res_clear[i]) entry_d[i].valid = 1'b0;
                if (alloc && (grant_tag == BR_TAG_t'(i))) begin
                    entry_d[i].valid    = 1'b1;
                    entry_d[i].rob_idx  = dispatch_ROB_idx;
                    entry_d[i].dep_mask = valid_mask & ~res_clear;
                end
            end
        end
    end

    // NOTE: the checkpoint array is a handful of flops, not a RAM, so it takes the
    // async reset like any other state; a RAM-style array would be left unreset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BR; i++) entry_q[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < NUM_BR; i++) entry_q[i] <= entry_d[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= NORMAL;
            squash_q <= '0;
            rb_idx_q <= '0;
        end else if (en) begin
            case (state_q)
                NORMAL: begin
                    if (mis_ok) begin
                        state_q  <= ROLLBACK;
                        squash_q <= squash_next;
                        rb_idx_q <= entry_q[br_resolve_tag].rob_idx;
                    end
                end
                ROLLBACK: state_q <= RECOVER;
                RECOVER:  state_q <= NORMAL;
                default:  state_q <= NORMAL;
            endcase
        end
    end

    assign rollback_en      = (state_q == ROLLBACK);
    assign squash_mask      = rollback_en ? squash_q : '0;
    assign ROB_rollback_idx = rb_idx_q;
    assign br_mask_out      = valid_mask;
    assign br_tag_out       = grant_tag;

endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Self-checking bench for branch_checkpoint_ctrl: directed vectors, corner sequences, random vs. model.
// Build with or without CKPT_BYPASS_FREE_EN to match the RTL.
module tb_branch_checkpoint_ctrl;
    import sys_defs::*;

`ifdef CKPT_BYPASS_FREE_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic     clock;
    logic     reset;
    logic     en;
    logic     dispatch_en;
    logic     dispatch_is_br;
    ROB_IDX_t dispatch_ROB_idx;
    logic     br_resolve_en;
    BR_TAG_t  br_resolve_tag;
    logic     br_mispredict;
    logic     dispatch_stall;
    BR_TAG_t  br_tag_out;
    BR_MASK_t br_mask_out;
    BR_MASK_t squash_mask;
    logic     rollback_en;
    ROB_IDX_t ROB_rollback_idx;

    branch_checkpoint_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .en               (en),
        .dispatch_en      (dispatch_en),
        .dispatch_is_br   (dispatch_is_br),
        .dispatch_ROB_idx (dispatch_ROB_idx),
        .br_resolve_en    (br_resolve_en),
        .br_resolve_tag   (br_resolve_tag),
        .br_mispredict    (br_mispredict),
        .dispatch_stall   (dispatch_stall),
        .br_tag_out       (br_tag_out),
        .br_mask_out      (br_mask_out),
        .squash_mask      (squash_mask),
        .rollback_en      (rollback_en),
        .ROB_rollback_idx (ROB_rollback_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: allocation age order replaces dependency masks.
    bit       m_valid [NUM_BR];
    int       m_rob   [NUM_BR];
    int       m_seq   [NUM_BR];
    int       m_phase;
    BR_MASK_t m_sq;
    int       m_rb;
    int       seq_ctr;
    bit       m_res_ok;

    logic     e_stall;
    int       e_tag;
    BR_MASK_t e_mask;
    logic     e_rb_en;
    BR_MASK_t e_sq;
    int       e_rb;

    task automatic model_reset();
        for (int i = 0; i < NUM_BR; i++) begin
            m_valid[i] = 1'b0;
            m_rob[i]   = 0;
            m_seq[i]   = 0;
        end
        m_phase = 0;
        m_sq    = '0;
        m_rb    = 0;
        seq_ctr = 0;
    endtask

    task automatic model_eval();
        int free_lo;
        bit full;
        bit bypass_hit;
        free_lo = -1;
        e_mask  = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (m_valid[i]) e_mask[i] = 1'b1;
            else if (free_lo < 0) free_lo = i;
        end
        full       = (free_lo < 0);
        m_res_ok   = br_resolve_en && !br_mispredict && (m_phase == 0) && m_valid[br_resolve_tag];
        bypass_hit = BYPASS && full && m_res_ok;
        if (bypass_hit)  e_tag = int'(br_resolve_tag);
        else if (full)   e_tag = 0;
        else             e_tag = free_lo;
        e_stall = (dispatch_is_br && full && !bypass_hit) || (br_resolve_en && br_mispredict) || (m_phase != 0);
        e_rb_en = (m_phase == 1);
        e_sq    = (m_phase == 1) ? m_sq : '0;
        e_rb    = m_rb;
    endtask

    task automatic model_update();
        int t;
        if (!en) return;
        t = int'(br_resolve_tag);
        case (m_phase)
            1: m_phase = 2;
            2: m_phase = 0;
            default: begin
                if (br_resolve_en && br_mispredict && m_valid[t]) begin
                    m_sq = '0;
                    for (int i = 0; i < NUM_BR; i++) begin
                        if (m_valid[i] && (i == t || m_seq[i] > m_seq[t])) begin
                            m_sq[i]    = 1'b1;
                            m_valid[i] = 1'b0;
                        end
                    end
                    m_rb    = m_rob[t];
                    m_phase = 1;
                end else begin
                    if (m_res_ok) m_valid[t] = 1'b0;
                    if (dispatch_en && dispatch_is_br && !e_stall) begin
                        m_valid[e_tag] = 1'b1;
                        m_rob[e_tag]   = int'(dispatch_ROB_idx);
                        m_seq[e_tag]   = seq_ctr;
                        seq_ctr++;
                    end
                end
            end
        endcase
    endtask

    task automatic drive(input logic i_en, input logic i_de, input logic i_br, input int i_rob,
                         input logic i_re, input int i_rt, input logic i_mp);
        en               = i_en;
        dispatch_en      = i_de;
        dispatch_is_br   = i_br;
        dispatch_ROB_idx = ROB_IDX_t'(i_rob);
        br_resolve_en    = i_re;
        br_resolve_tag   = BR_TAG_t'(i_rt);
        br_mispredict    = i_mp;
    endtask

    task automatic settle();
        #3;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic cmp_model(input string ctx);
        check({ctx, " stall"},    32'(dispatch_stall),   32'(e_stall));
        check({ctx, " tag"},      32'(br_tag_out),       32'(e_tag));
        check({ctx, " mask"},     32'(br_mask_out),      32'(e_mask));
        check({ctx, " rb_en"},    32'(rollback_en),      32'(e_rb_en));
        check({ctx, " squash"},   32'(squash_mask),      32'(e_sq));
        check({ctx, " rb_idx"},   32'(ROB_rollback_idx), 32'(e_rb));
    endtask

    typedef struct {
        logic     v_en, v_de, v_br;
        int       v_rob;
        logic     v_re;
        int       v_rt;
        logic     v_mp;
        logic     x_stall;
        int       x_tag;
        BR_MASK_t x_mask;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Resolve of invalid tag 2 first, then four branches, then a fifth that must stall.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 0,  1'b1, 2, 1'b0, 1'b0, 0, 4'b0000};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 3,  1'b0, 0, 1'b0, 1'b0, 0, 4'b0000};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 5,  1'b0, 0, 1'b0, 1'b0, 1, 4'b0001};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 7,  1'b0, 0, 1'b0, 1'b0, 2, 4'b0011};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 9,  1'b0, 0, 1'b0, 1'b0, 3, 4'b0111};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 11, 1'b0, 0, 1'b0, 1'b1, 0, 4'b1111};

        model_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        #2;
        check("reset stall",  32'(dispatch_stall),   32'd0);
        check("reset tag",    32'(br_tag_out),       32'd0);
        check("reset mask",   32'(br_mask_out),      32'd0);
        check("reset rb_en",  32'(rollback_en),      32'd0);
        check("reset squash", 32'(squash_mask),      32'd0);
        check("reset rb_idx", 32'(ROB_rollback_idx), 32'd0);
        #10;
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].v_en, vecs[v].v_de, vecs[v].v_br, vecs[v].v_rob,
                  vecs[v].v_re, vecs[v].v_rt, vecs[v].v_mp);
            settle();
            check($sformatf("vec%0d stall", v), 32'(dispatch_stall), 32'(vecs[v].x_stall));
            check($sformatf("vec%0d tag", v),   32'(br_tag_out),     32'(vecs[v].x_tag));
            check($sformatf("vec%0d mask", v),  32'(br_mask_out),    32'(vecs[v].x_mask));
            advance();
        end

        // Mispredict of tag 1 with tags 0-3 live.
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 1'b1);
        settle();
        check("mis stall", 32'(dispatch_stall), 32'd1);
        advance();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        settle();
        check("rollback rb_en",  32'(rollback_en),      32'd1);
        check("rollback idx",    32'(ROB_rollback_idx), 32'd5);
        check("rollback squash", 32'(squash_mask),      32'b1110);
        cmp_model("rollback");
        advance();
        settle();
        check("recover rb_en",  32'(rollback_en),    32'd0);
        check("recover squash", 32'(squash_mask),    32'd0);
        check("recover stall",  32'(dispatch_stall), 32'd1);
        advance();
        settle();
        check("normal stall", 32'(dispatch_stall), 32'd0);
        check("normal mask",  32'(br_mask_out),    32'b0001);

        // Refill to full, then resolve tag 1 while a branch dispatches.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b1, 12 + k, 1'b0, 0, 1'b0);
            settle();
            check($sformatf("refill%0d tag", k), 32'(br_tag_out), 32'(k + 1));
            advance();
        end
        drive(1'b1, 1'b1, 1'b1, 20, 1'b1, 1, 1'b0);
        settle();
        check("free+disp stall", 32'(dispatch_stall), BYPASS ? 32'd0 : 32'd1);
        if (BYPASS) check("free+disp tag", 32'(br_tag_out), 32'd1);
        cmp_model("free+disp");
        advance();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        settle();
        check("free+disp mask", 32'(br_mask_out), BYPASS ? 32'b1111 : 32'b1101);

        // Mispredict of tag 0 held while en=0, then released.
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1);
        settle();
        check("en0 mis stall", 32'(dispatch_stall), 32'd1);
        advance();
        settle();
        check("en0 no rb_en", 32'(rollback_en), 32'd0);
        check("en0 mask",     32'(br_mask_out), BYPASS ? 32'b1111 : 32'b1101);
        en = 1'b1;
        settle();
        advance();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        settle();
        check("en1 rb_en",  32'(rollback_en),      32'd1);
        check("en1 idx",    32'(ROB_rollback_idx), 32'd3);
        check("en1 squash", 32'(squash_mask),      BYPASS ? 32'b1111 : 32'b1101);
        cmp_model("en1");

        // Reset pulse while in ROLLBACK.
        reset = 1'b0;
        #1;
        check("midrst rb_en",  32'(rollback_en), 32'd0);
        check("midrst mask",   32'(br_mask_out), 32'd0);
        check("midrst squash", 32'(squash_mask), 32'd0);
        model_reset();
        reset = 1'b1;
        model_eval();
        advance();
        drive(1'b1, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0);
        settle();
        check("post-rst tag",   32'(br_tag_out),     32'd0);
        check("post-rst stall", 32'(dispatch_stall), 32'd0);
        advance();

        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 8) != 0, ($urandom % 10) < 7, ($urandom % 2) == 1,
                  int'($urandom_range(NUM_ROB - 1, 0)),
                  ($urandom % 10) < 4, int'($urandom_range(NUM_BR - 1, 0)),
                  ($urandom % 6) == 0);
            settle();
            cmp_model($sformatf("rand%0d", c));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_checkpoint_ctrl.md
BRANCH_CHECKPOINT_CTRL -- requirements
Module: branch_checkpoint_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low; reset asserts when reset=0.
REQ-003 SHALL have port en, input, 1 bit: global pipeline enable; state holds when en=0.
REQ-004 SHALL have port dispatch_en, input, 1 bit: an instruction dispatches this cycle.
REQ-005 SHALL have port dispatch_is_br, input, 1 bit: the dispatching instruction is a branch and needs a map-table checkpoint.
REQ-006 SHALL have port dispatch_ROB_idx, input, $clog2(`NUM_ROB) bits: ROB slot of the dispatching instruction.
REQ-007 SHALL have port br_resolve_en, input, 1 bit: a branch resolves this cycle.
REQ-008 SHALL have port br_resolve_tag, input, $clog2(`NUM_BR) bits: tag of the resolving branch.
REQ-009 SHALL have port br_mispredict, input, 1 bit: the resolving branch mispredicted; qualified by br_resolve_en.
REQ-010 SHALL have port dispatch_stall, output, 1 bit: dispatch is blocked this cycle.
REQ-011 SHALL have port br_tag_out, output, $clog2(`NUM_BR) bits: tag granted to the dispatching branch.
REQ-012 SHALL have port br_mask_out, output, `NUM_BR bits: live-checkpoint mask for the dispatching instruction.
REQ-013 SHALL have port squash_mask, output, `NUM_BR bits: tags killed by the current rollback.
REQ-014 SHALL have port rollback_en, output, 1 bit: drives Map_Table rollback_en.
REQ-015 SHALL have port ROB_rollback_idx, output, $clog2(`NUM_ROB) bits: drives Map_Table ROB_rollback_idx.

Function
REQ-016 SHALL keep per-tag entry {valid, ROB_idx, dep_mask}, where dep_mask = live mask at allocation, i.e. the set of older checkpoints.
REQ-017 SHALL keep live_mask = OR of valid bits; br_mask_out = live_mask (combinational).
REQ-018 SHALL present br_tag_out = lowest-index invalid tag, combinationally, same cycle.
REQ-019 SHALL assert dispatch_stall when (dispatch_is_br && all tags valid) || (br_resolve_en && br_mispredict) || state != NORMAL.
REQ-020 SHALL allocate on the next edge when dispatch_en && dispatch_is_br && !dispatch_stall: valid=1, ROB_idx=dispatch_ROB_idx, dep_mask=live_mask.
REQ-021 SHALL, on a correct resolve (br_resolve_en && !br_mispredict) of a valid tag, clear that tag's valid bit and clear that bit in every dep_mask on the next edge.
REQ-022 SHALL ignore a resolve of an invalid tag entirely.
REQ-023 SHALL, on a mispredict of valid tag t, move NORMAL->ROLLBACK, latch ROB_rollback_idx=entry[t].ROB_idx and squash_mask = {t} OR {all tags whose dep_mask has bit t}, then clear valid on every squash_mask tag.
REQ-024 SHALL have FSM states NORMAL, ROLLBACK, RECOVER: ROLLBACK->RECOVER after exactly 1 cycle, RECOVER->NORMAL after exactly 1 cycle.
REQ-025 SHALL assert rollback_en only in ROLLBACK, for exactly 1 cycle, registered 1 cycle after the mispredict input.
REQ-026 SHALL drive squash_mask=0 outside ROLLBACK.
REQ-027 SHALL, on a same-cycle correct resolve and branch dispatch, perform both operations; the freed tag is not grantable that cycle unless CKPT_BYPASS_FREE_EN (REQ-031).
REQ-028 SHALL ignore resolves while not in NORMAL; the squash takes precedence.
REQ-029 SHALL, with en=0, hold all state and FSM while outputs track current state.

Reset
REQ-030 SHALL, on reset=0, asynchronously clear all valid bits, ROB_idx and dep_mask, set state=NORMAL, and force rollback_en=0, squash_mask=0, ROB_rollback_idx=0 and br_mask_out=0; br_tag_out=0; dispatch_stall=0 unless driven by inputs. Reset mid-ROLLBACK drops rollback_en immediately.

Configuration
REQ-031 SHALL support `CKPT_BYPASS_FREE_EN`: when defined, if all tags are valid and a same-cycle correct resolve frees tag r, dispatch does not stall, br_tag_out=r, and r is reallocated (dep_mask excluding r); when undefined, the branch stalls that cycle.

Structure
REQ-032 SHALL place `NUM_BR, BR_TAG_t, BR_MASK_t, CKPT_ENTRY_t and enum CKPT_STATE_t {NORMAL, ROLLBACK, RECOVER} in the shared sys_defs package.
REQ-033 SHALL implement lowest-free selection as sub-module br_tag_pick (valid mask in -> tag and full out).

Verification (`NUM_BR=4, `NUM_ROB=32)
REQ-034 SHALL cover: 4 branch dispatches at ROB 3,5,7,9 -> tags 0,1,2,3; masks 0000,0001,0011,0111; 5th branch -> dispatch_stall=1.
REQ-035 SHALL cover: full table, correct resolve of tag 1 with branch dispatch in the same cycle -> stall=1 without the macro; with the macro: tag 1 granted, stall=0.
REQ-036 SHALL cover: tags 0-3 live, mispredict of tag 1 -> next cycle rollback_en=1, ROB_rollback_idx=5, squash_mask=1110; 2 cycles later state NORMAL and live_mask=0001.
REQ-037 SHALL cover: resolve of invalid tag 2 -> no state change.
REQ-038 SHALL cover: reset=0 pulsed during ROLLBACK -> rollback_en=0 immediately; all tags free; next branch gets tag 0.
REQ-039 SHALL cover: en=0 during a mispredict cycle -> no transition; the transition occurs when en rises if the inputs are held.
